// File: rtl/cfg_commit_ctrl.sv
// Double-buffered EFI configuration bank: SPI writes land in staging and are copied to the
// active bank atomically at an engine-safe point. Define CFG_COMMIT_TIMEOUT_EN for a forced-commit timeout.
module cfg_commit_ctrl #(
  parameter int          NREGS       = 16,
  parameter int          AW          = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [15:0]           wr_data,
  input  logic                  commit_req,
  input  logic                  trigger,
  input  logic                  synced,
  input  logic [5:0]            busy_mask,
  input  logic [AW-1:0]         rd_addr,
  output logic [15:0]           rd_data,
  output logic [16*NREGS-1:0]   active_flat,
  output logic [NREGS-1:0]      dirty_mask,
  output logic                  pending,
  output logic                  commit_ack,
  output logic                  commit_forced
);
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_QUIET, COMMIT} state_e;

  state_e                  state_q, state_d;
  logic                    forced_q, forced_d;
  logic [NREGS-1:0][15:0]  staging_q, active_q;
  logic [NREGS-1:0]        dirty_q;
  logic [15:0]             rd_data_q;
  logic                    commit_ack_q, commit_forced_q;
  logic                    wr_ok, rd_ok, tmo_hit;

  assign wr_ok = wr_en && (32'(wr_addr) < NREGS);
  assign rd_ok = 32'(rd_addr) < NREGS;

`ifdef CFG_COMMIT_TIMEOUT_EN
  logic [31:0] tmo_q;

  // ARMED is only entered from IDLE, so holding zero in IDLE clears it on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      tmo_q <= '0;
    else if (state_q == IDLE)                        tmo_q <= '0;
    else if (state_q == ARMED || state_q == WAIT_QUIET) tmo_q <= tmo_q + 32'd1;
  end

  assign tmo_hit = (state_q == ARMED || state_q == WAIT_QUIET) && (tmo_q == TIMEOUT_CYC - 32'd1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    forced_d = 1'b0;
    case (state_q)
      IDLE:       if (commit_req) state_d = synced ? ARMED : COMMIT;
      ARMED: begin
        if (!synced || tmo_hit) begin
          state_d  = COMMIT;
          forced_d = 1'b1;
        end else if (trigger) begin
          state_d = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (!synced || tmo_hit) begin
          state_d  = COMMIT;
          forced_d = 1'b1;
        end else if (busy_mask == 6'd0) begin
          state_d = COMMIT;
        end
      end
      COMMIT:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      forced_q <= forced_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q       <= '0;
      active_q        <= '0;
      dirty_q         <= '0;
      rd_data_q       <= '0;
      commit_ack_q    <= 1'b0;
      commit_forced_q <= 1'b0;
    end else begin
      commit_ack_q <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        active_q        <= staging_q;
        dirty_q         <= '0;
        commit_forced_q <= forced_q;
      end
      // Placed after the clear so a write in the COMMIT cycle keeps its dirty bit.
      if (wr_ok) begin
        staging_q[wr_addr] <= wr_data;
        dirty_q[wr_addr]   <= 1'b1;
      end
      rd_data_q <= rd_ok ? active_q[rd_addr] : 16'd0;
    end
  end

  assign rd_data       = rd_data_q;
  assign active_flat   = active_q;
  assign dirty_mask    = dirty_q;
  assign pending       = (state_q != IDLE);
  assign commit_ack    = commit_ack_q;
  assign commit_forced = commit_forced_q;
endmodule

// File: tb/tb_cfg_commit_ctrl.sv
// Randomized bench for cfg_commit_ctrl: each commit transaction has its ack edge computed up front
// from the trigger/busy/sync schedule; a staging/active array model tracks contents.
module tb_cfg_commit_ctrl;
  localparam int          NREGS = 12;
  localparam int          AW    = 4;
  localparam logic [31:0] TMO   = 32'd100;

  logic                clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0, rd_addr = '0;
  logic [15:0]         wr_data = '0;
  logic                commit_req = 1'b0, trigger = 1'b0, synced = 1'b0;
  logic [5:0]          busy_mask = '0;
  logic [15:0]         rd_data;
  logic [16*NREGS-1:0] active_flat;
  logic [NREGS-1:0]    dirty_mask;
  logic                pending, commit_ack, commit_forced;

  int errs = 0, checks = 0;

  logic [15:0]      stg [NREGS];
  logic [15:0]      act [NREGS];
  logic [NREGS-1:0] dmod;
  logic             fmod;

  always #5 clk = ~clk;

  cfg_commit_ctrl #(.NREGS(NREGS), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .trigger(trigger), .synced(synced), .busy_mask(busy_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .active_flat(active_flat), .dirty_mask(dirty_mask),
    .pending(pending), .commit_ack(commit_ack), .commit_forced(commit_forced)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16*NREGS-1:0] pack_act();
    logic [16*NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[16*i +: 16] = act[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      stg[i] = '0;
      act[i] = '0;
    end
    dmod = '0;
    fmod = 1'b0;
  endtask

  // One clock edge: random write/readback, model update, then check after the edge.
  task automatic step(input bit commit_now, input bit exp_pend, input bit frc);
    logic [15:0] exp_rd;
    wr_en   = ($urandom_range(0, 9) < 4) || (commit_now && $urandom_range(0, 1) == 1);
    wr_addr = AW'($urandom_range(0, 15));
    wr_data = 16'($urandom);
    rd_addr = AW'($urandom_range(0, 15));
    exp_rd  = (int'(rd_addr) < NREGS) ? act[rd_addr] : 16'd0;
    if (commit_now) begin
      for (int i = 0; i < NREGS; i++) act[i] = stg[i];
      dmod = '0;
      fmod = frc;
    end
    if (wr_en && int'(wr_addr) < NREGS) begin
      stg[wr_addr]  = wr_data;
      dmod[wr_addr] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ack",    commit_ack,    commit_now);
    chk("pend",   pending,       exp_pend);
    chk("rd",     rd_data,       exp_rd);
    chk("dirty",  dirty_mask,    dmod);
    chk("active", active_flat,   pack_act());
    chk("forced", commit_forced, fmod);
    commit_req = 1'b0;
    trigger    = 1'b0;
  endtask

  // kind 0: unsynced; 1: trigger + busy; 2: sync lost in ARMED; 3: sync lost in WAIT_QUIET; 4: no trigger
  task automatic txn(input int kind);
    int d, b, j, e;
    bit frc;
    d = $urandom_range(1, 20);
    b = $urandom_range(0, 8);
    j = $urandom_range(1, 8);
    case (kind)
      0: begin e = 1;         frc = 1'b0; end
      1: begin e = d + b + 2; frc = 1'b0; end
      2: begin e = d + 1;     frc = 1'b1; end
      3: begin e = d + j + 1; frc = 1'b1; end
      default: begin
`ifdef CFG_COMMIT_TIMEOUT_EN
        d = 1 << 30;
        e = int'(TMO) + 1;
`else
        d = 9999;
        e = 10000;
`endif
        frc = 1'b1;
      end
    endcase
    for (int k = 0; k <= e + 2; k++) begin
      commit_req = (k == 0) || (k <= e && $urandom_range(0, 3) == 0);
      case (kind)
        0: begin
          synced    = 1'b0;
          trigger   = ($urandom_range(0, 1) == 1);
          busy_mask = 6'($urandom);
        end
        1: begin
          synced    = 1'b1;
          trigger   = (k == d) || (k == 0 && $urandom_range(0, 1) == 1) || (k > d && $urandom_range(0, 3) == 0);
          busy_mask = (k > d && k <= d + b) ? 6'($urandom_range(1, 63)) : (k <= d ? 6'($urandom) : 6'd0);
        end
        2: begin
          synced    = (k < d);
          trigger   = (k == 0 && $urandom_range(0, 1) == 1);
          busy_mask = 6'($urandom);
        end
        3: begin
          synced    = (k < d + j);
          trigger   = (k == d);
          busy_mask = (k > d) ? 6'($urandom_range(1, 63)) : 6'($urandom);
        end
        default: begin
          synced    = (k < d);
          trigger   = 1'b0;
          busy_mask = 6'($urandom);
        end
      endcase
      step(k == e, k < e, frc);
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_pend",   pending,       1'b0);
    chk("rst_ack",    commit_ack,    1'b0);
    chk("rst_forced", commit_forced, 1'b0);
    chk("rst_dirty",  dirty_mask,    '0);
    chk("rst_active", active_flat,   '0);
    chk("rst_rd",     rd_data,       16'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) txn(n % 4);
    txn(4);

    // Reset while a commit is pending.
    synced     = 1'b1;
    trigger    = 1'b0;
    busy_mask  = 6'd0;
    commit_req = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_pend",   pending,       1'b0);
    chk("mid_ack",    commit_ack,    1'b0);
    chk("mid_forced", commit_forced, 1'b0);
    chk("mid_dirty",  dirty_mask,    '0);
    chk("mid_active", active_flat,   '0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = AW'(i);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rd", rd_data, 16'd0);
    end
    model_clear();
    rst_n = 1'b1;
    txn(0);
    txn(1);
    txn(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
